// File: rtl/branch_resolve_unit.sv
// Resolves executed branches against their predictions, pulses a fetch redirect on a
// mispredict, and queues every resolved branch for draining onto the predictor training port.
module branch_resolve_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  ex_type,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic [9:0]  ex_bhr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        fe_flush_ack,
  output logic        update_en,
  input  logic        update_ready,
  output logic [31:0] update_pc,
  output logic [9:0]  update_BHR,
  output logic [1:0]  update_type,
  output logic [31:0] update_BTA,
  output logic        branch_en,
  output logic        btb_write,
  output logic        tc_write,
  output logic [31:0] mispredict_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, REDIRECT, WAIT_FLUSH} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  bhr;
    logic [1:0]  typ;
    logic [31:0] target;
    logic        taken;
    logic        btb;
    logic        tc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]   mis_cnt_q, mis_cnt_d;
  logic          full, empty, push, pop, mispredict;
  entry_t        new_e, out_e;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign ex_ready   = ~full & (state_q == RUN);
  assign push       = ex_valid & ex_ready;
  assign pop        = ~empty & update_ready;
  assign mispredict = (ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target));

  always_comb begin
    new_e        = '0;
    new_e.pc     = ex_pc;
    new_e.bhr    = ex_bhr;
    new_e.typ    = ex_type;
    new_e.target = ex_target;
    new_e.taken  = ex_taken;
    new_e.btb    = ex_taken & (ex_type != 2'b10) & ((ex_pred_target != ex_target) | ~ex_pred_taken);
    new_e.tc     = ex_taken & (ex_type == 2'b11);
  end

  // Head is masked while empty so stale storage never leaks onto the training port.
  always_comb begin
    out_e = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign update_en        = ~empty;
  assign update_pc        = out_e.pc;
  assign update_BHR       = out_e.bhr;
  assign update_type      = out_e.typ;
  assign update_BTA       = out_e.target;
  assign branch_en        = out_e.taken;
  assign btb_write        = out_e.btb;
  assign tc_write         = out_e.tc;
  assign redirect_valid   = (state_q == REDIRECT);
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = mis_cnt_q;

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    mis_cnt_d     = mis_cnt_q;
    wr_ptr_d      = wr_ptr_q + AW'(push);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    count_d       = count_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      RUN: begin
        if (push && mispredict) begin
          state_d       = REDIRECT;
          redirect_pc_d = ex_taken ? ex_target : ex_pc + 32'd4;
          mis_cnt_d     = mis_cnt_q + 32'd1;
        end
      end
      REDIRECT:   state_d = WAIT_FLUSH;
      WAIT_FLUSH: if (fe_flush_ack) state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_pc_q <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_e;
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed plan cases followed by random traffic,
// with a cycle-level behavioural model and a decoupled output monitor.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;

  logic        clk = 0, reset = 1;
  logic        ex_valid = 0, ex_taken = 0, ex_pred_taken = 0, fe_flush_ack = 0, update_ready = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic [1:0]  ex_type = 0;
  logic [9:0]  ex_bhr = 0;
  logic        ex_ready, redirect_valid, update_en, branch_en, btb_write, tc_write;
  logic [31:0] redirect_pc, update_pc, update_BTA, mispredict_count;
  logic [9:0]  update_BHR;
  logic [1:0]  update_type;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_type(ex_type), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_bhr(ex_bhr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fe_flush_ack(fe_flush_ack), .update_en(update_en),
    .update_ready(update_ready), .update_pc(update_pc), .update_BHR(update_BHR),
    .update_type(update_type), .update_BTA(update_BTA), .branch_en(branch_en),
    .btb_write(btb_write), .tc_write(tc_write), .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [9:0]  bhr;
    logic [1:0]  typ;
    logic [31:0] tgt;
    logic        tk, btb, tc;
  } exp_t;

  typedef enum {M_RUN, M_REDIR, M_WAIT} mode_t;

  exp_t        dq[$];
  logic [31:0] rq[$];
  int          n_chk = 0, n_fail = 0;
  mode_t       mode = M_RUN;
  int          occ = 0;
  logic [31:0] mcnt = 0;
  bit          rst_pend = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; model state reflects what the DUT should show after the edge.
  task automatic step(input bit rst, input bit v, input logic [31:0] pc, input logic [1:0] typ,
                      input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                      input logic [9:0] bhr, input bit ur, input bit ack);
    bit   rdy, acc, mis, pp;
    exp_t e;
    @(posedge clk); #1;
    if (rst_pend) begin
      dq.delete(); rq.delete();
      occ = 0; mode = M_RUN; mcnt = 0; rst_pend = 0;
      chk("rst_update_pc", update_pc, 0);
      chk("rst_update_BHR", 32'(update_BHR), 0);
      chk("rst_update_type", 32'(update_type), 0);
      chk("rst_update_BTA", update_BTA, 0);
      chk("rst_branch_en", 32'(branch_en), 0);
      chk("rst_btb_write", 32'(btb_write), 0);
      chk("rst_tc_write", 32'(tc_write), 0);
      chk("rst_redirect_pc", redirect_pc, 0);
    end
    rdy = (occ < DEPTH) && (mode == M_RUN);
    chk("ex_ready", 32'(ex_ready), 32'(rdy));
    chk("update_en", 32'(update_en), 32'(occ > 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(mode == M_REDIR));
    chk("mispredict_count", mispredict_count, mcnt);

    reset = rst; ex_valid = v; ex_pc = pc; ex_type = typ; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt; ex_bhr = bhr;
    update_ready = ur & !rst; fe_flush_ack = ack;

    if (rst) rst_pend = 1;
    else begin
      pp  = (occ > 0) && ur;
      acc = v && rdy;
      mis = (tk != ptk) || (tk && (tgt != ptgt));
      if (acc) begin
        e.pc = pc; e.bhr = bhr; e.typ = typ; e.tgt = tgt; e.tk = tk;
        e.btb = tk && (typ != 2'b10) && ((ptgt != tgt) || !ptk);
        e.tc  = tk && (typ == 2'b11);
        dq.push_back(e);
      end
      occ = occ + int'(acc) - int'(pp);
      case (mode)
        M_RUN: if (acc && mis) begin
          mode = M_REDIR;
          mcnt = mcnt + 1;
          rq.push_back(tk ? tgt : pc + 32'd4);
        end
        M_REDIR: mode = M_WAIT;
        M_WAIT:  if (ack) mode = M_RUN;
        default: mode = M_RUN;
      endcase
    end
  endtask

  task automatic idle(input bit ur, input bit ack);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ur, ack);
  endtask

  // Monitor: retires expected entries whenever the DUT presents them.
  exp_t me;
  always @(negedge clk) begin
    if (update_en && update_ready) begin
      if (dq.size() == 0) chk("update_unexpected", 1, 0);
      else begin
        me = dq.pop_front();
        chk("update_pc", update_pc, me.pc);
        chk("update_BHR", 32'(update_BHR), 32'(me.bhr));
        chk("update_type", 32'(update_type), 32'(me.typ));
        chk("update_BTA", update_BTA, me.tgt);
        chk("branch_en", 32'(branch_en), 32'(me.tk));
        chk("btb_write", 32'(btb_write), 32'(me.btb));
        chk("tc_write", 32'(tc_write), 32'(me.tc));
      end
    end
    if (redirect_valid) begin
      if (rq.size() == 0) chk("redirect_unexpected", 1, 0);
      else chk("redirect_pc", redirect_pc, rq.pop_front());
    end
  end

  initial begin
    logic [31:0] pc, tgt, ptgt;
    logic [1:0]  typ;
    bit          tk, ptk;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    // Correct prediction
    step(0, 1, 32'h1000, 2'b00, 1, 32'h2000, 1, 32'h2000, 10'h155, 1, 0);
    idle(1, 0); idle(1, 0);
    // Direction mispredict, ack held off for a while
    step(0, 1, 32'h1000, 2'b00, 0, 32'h0, 1, 32'h2000, 10'h0aa, 1, 0);
    idle(1, 0); idle(1, 0); idle(1, 0); idle(1, 1); idle(1, 0);
    // Indirect target mispredict; ack during REDIRECT must be ignored
    step(0, 1, 32'h4000, 2'b11, 1, 32'h3000, 1, 32'h2000, 10'h3ff, 1, 0);
    idle(1, 1); idle(1, 0); idle(1, 1); idle(1, 0);
    // PC wrap on not-taken redirect
    step(0, 1, 32'hFFFFFFFC, 2'b01, 0, 32'h0, 1, 32'h10, 10'h001, 1, 0);
    idle(1, 0); idle(1, 1); idle(1, 0);
    // Backpressure: fill while the predictor stalls, then drain
    for (int i = 0; i < DEPTH + 2; i++)
      step(0, 1, 32'h5000 + 32'(i*4), 2'(i), 1, 32'h6000 + 32'(i), 1, 32'h6000 + 32'(i), 10'(i), 0, 0);
    for (int i = 0; i < DEPTH + 2; i++)
      step(0, 1, 32'h7000 + 32'(i*4), 2'b00, 0, 32'h0, 0, 32'h0, 10'(i), 1, 0);
    idle(1, 0); idle(1, 0); idle(1, 0);
    // Reset while waiting for flush with three entries queued
    step(0, 1, 32'h8000, 2'b00, 1, 32'h8100, 1, 32'h8100, 10'h011, 0, 0);
    step(0, 1, 32'h8004, 2'b00, 0, 32'h0,    0, 32'h0,    10'h012, 0, 0);
    step(0, 1, 32'h8008, 2'b00, 1, 32'h9000, 0, 32'h9000, 10'h013, 0, 0);
    idle(0, 0); idle(0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      pc   = $urandom & 32'hFFFF_FFFC;
      typ  = 2'($urandom_range(0, 3));
      tk   = 1'($urandom_range(0, 1));
      tgt  = ($urandom_range(0, 2) == 0) ? $urandom : 32'h2000 + 32'($urandom_range(0, 3) * 4);
      ptk  = ($urandom_range(0, 4) == 0) ? !tk : tk;
      ptgt = ($urandom_range(0, 4) == 0) ? tgt ^ 32'h40 : tgt;
      step($urandom_range(0, 249) == 0, $urandom_range(0, 9) < 7, pc, typ, tk, tgt, ptk, ptgt,
           10'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
    end
    for (int i = 0; i < 16; i++) idle(1, 1);
    @(negedge clk); #1;
    chk("drain_empty", 32'(dq.size()), 0);
    chk("redirects_seen", 32'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
